timer_arbiter: RTL and testbench
================================

TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter CW, default 4, width of duration fields and of the internal down counter.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  per-requester request level; bit i belongs to requester i.
REQ-005 dur  input  4*CW  packed durations; dur[i*CW +: CW] belongs to requester i; sampled only at grant decision.
REQ-006 gnt  output  4  one-hot grant level, all-zero when idle.
REQ-007 busy  output  1  high while any gnt bit is high.
REQ-008 count  output  CW  current down-counter value.
REQ-009 done  output  1  single-cycle pulse on normal completion of a slot.
REQ-010 aborted  output  1  single-cycle pulse when a slot ends early.
REQ-011 done_id  output  2  index of the requester whose slot just ended; valid while done or aborted is high.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-013 In IDLE with req != 0, the block SHALL select one winner, load count <= dur[winner], set gnt[winner], and enter RUN on the next edge.
REQ-014 In IDLE with req == 0, the block SHALL hold gnt = 0, busy = 0 and count unchanged.
REQ-015 In RUN with req[winner] high and count > 0, the block SHALL decrement count by 1 per cycle and hold gnt.
REQ-016 In RUN with req[winner] high and count == 0, the block SHALL take the following actions on the next edge:
- clear gnt;
- pulse done for 1 cycle with done_id = winner;
- return to IDLE.
REQ-017 A slot of duration D SHALL hold gnt for exactly D+1 cycles; D = 0 SHALL give a 1-cycle grant.
REQ-018 Grant latency from req rising in IDLE to gnt high SHALL be 1 cycle.
REQ-019 In RUN, if req[winner] falls, the block SHALL take the following actions on the next edge:
- clear gnt;
- pulse aborted for 1 cycle with done_id = winner;
- leave count at its current value;
- return to IDLE.
- done SHALL NOT pulse.
REQ-020 If req[winner] falls in the same cycle that count == 0, the abort rule SHALL take precedence.
REQ-021 Changes on req of non-winners and on dur during RUN SHALL have no effect on the current slot.
REQ-022 The cycle in which done or aborted pulses is an IDLE cycle and SHALL arbitrate normally, giving a 1-cycle gnt gap between back-to-back slots.
REQ-023 count SHALL never wrap: decrement occurs only when count > 0.
REQ-024 done and aborted SHALL never be high in the same cycle.

Reset
REQ-025 Asserting rst at any time SHALL immediately force the following, including mid-slot, with no done or aborted pulse generated:
- state IDLE;
- gnt = 0, busy = 0;
- count = 0;
- done = 0, aborted = 0, done_id = 0;
- round-robin pointer = 0.
REQ-026 After rst deasserts, the first arbitration SHALL occur on the first rising clk edge with req != 0.

Configuration
REQ-027 With TIMER_ARB_RR_EN defined, arbitration SHALL be round-robin:
- after requester i is granted, priority order SHALL be i+1, i+2, i+3, i (mod 4);
- the pointer SHALL update at grant time.
REQ-028 Without TIMER_ARB_RR_EN, arbitration SHALL be fixed priority with req[0] highest and req[3] lowest, and no pointer state.

Verification
REQ-029 Single-requester slot:
- stimulus: req = 0001, dur0 = 3, held;
- required: gnt = 0001 for 4 cycles, count 3,2,1,0;
- then done = 1, done_id = 0, gnt = 0;
- then regrant after the 1-cycle gap.
REQ-030 Zero duration: req = 0100, dur2 = 0 -> gnt = 0100 for 1 cycle, then done, done_id = 2.
REQ-031 Abort: req = 0010, dur1 = 9, req dropped in the 3rd grant cycle -> the next cycle has aborted = 1, done_id = 1, done = 0, count = 7.
REQ-032 Contention with req = 1111 held and all dur = 1:
- with TIMER_ARB_RR_EN, grant order SHALL be 0,1,2,3,0;
- without it, grant order SHALL be 0,0,0.
REQ-033 Reset mid-slot: rst pulsed while count = 5 -> gnt, count and busy are 0 immediately, with no done and no aborted.
REQ-034 Abort/complete collision: req[winner] drops in the cycle count == 0 -> aborted = 1, done = 0.

Source files
------------

// File: rtl/timer_arbiter.sv
// Four-requester arbiter that grants a timed slot and reports done/aborted at its end.
// Define TIMER_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (req[0] highest).
module timer_arbiter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [4*CW-1:0] dur,
  output logic [3:0]    gnt,
  output logic          busy,
  output logic [CW-1:0] count,
  output logic          done,
  output logic          aborted,
  output logic [1:0]    done_id
);

  // state | meaning
  // IDLE  | no slot active, arbitrate every cycle
  // RUN   | slot owned by win_q, count_q counting down
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    win_q, win_d;
  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic [1:0]    done_id_q, done_id_d;

  logic [1:0]    rr_base;
  logic          win_valid;
  logic [1:0]    win_idx;

`ifdef TIMER_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;
  assign rr_base = ptr_q;
`else
  assign rr_base = 2'd0;
`endif

  // Scan from lowest priority to highest so the highest-priority requester wins last.
  always_comb begin
    logic [1:0] idx;
    idx       = 2'd0;
    win_valid = 1'b0;
    win_idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_base + 2'(k);
      if (req[idx]) begin
        win_valid = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    win_d     = win_q;
    count_d   = count_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    done_id_d = done_id_q;
`ifdef TIMER_ARB_RR_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = RUN;
          gnt_d   = 4'b0001 << win_idx;
          win_d   = win_idx;
          count_d = dur[int'(win_idx)*CW +: CW];
`ifdef TIMER_ARB_RR_EN
          ptr_d   = win_idx + 2'd1;
`endif
        end
      end
      default: begin
        // Abort is checked first so it wins over completion when count is already zero.
        if (!req[win_q]) begin
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          aborted_d = 1'b1;
          done_id_d = win_q;
        end else if (count_q == '0) begin
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          done_d    = 1'b1;
          done_id_d = win_q;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      win_q     <= 2'd0;
      count_q   <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      done_id_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      win_q     <= win_d;
      count_q   <= count_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      done_id_q <= done_id_d;
    end
  end

`ifdef TIMER_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 2'd0;
    else     ptr_q <= ptr_d;
  end
`endif

  assign gnt     = gnt_q;
  assign busy    = |gnt_q;
  assign count   = count_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign done_id = done_id_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter; slot-end events are queued when stimulus is driven
// and popped when done/aborted pulses.
module tb_timer_arbiter;

  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [3:0]    req;
  logic [4*CW-1:0] dur;
  logic [3:0]    gnt;
  logic          busy;
  logic [CW-1:0] count;
  logic          done;
  logic          aborted;
  logic [1:0]    done_id;

  typedef struct {
    logic       abrt;
    logic [1:0] id;
    logic [3:0] cnt;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad   = 0;

  timer_arbiter #(.CW(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .dur(dur),
    .gnt(gnt), .busy(busy), .count(count),
    .done(done), .aborted(aborted), .done_id(done_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    chk("done_and_aborted_exclusive", {31'b0, done & aborted}, 32'd0);
  endtask

  task automatic expect_end(input logic abrt, input logic [1:0] id, input logic [3:0] cnt);
    ev_t e;
    e.abrt = abrt;
    e.id   = id;
    e.cnt  = cnt;
    sb.push_back(e);
  endtask

  task automatic check_end(input string tag);
    ev_t e;
    chk({tag, "_pulse"}, {31'b0, done | aborted}, 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_done"},    {31'b0, done},    {31'b0, ~e.abrt});
      chk({tag, "_aborted"}, {31'b0, aborted}, {31'b0, e.abrt});
      chk({tag, "_done_id"}, {30'b0, done_id}, {30'b0, e.id});
      chk({tag, "_count"},   {28'b0, count},   {28'b0, e.cnt});
      chk({tag, "_gnt"},     {28'b0, gnt},     32'd0);
    end
  endtask

  initial begin
    int ord[$];
    rst = 1'b1;
    req = 4'b0000;
    dur = '0;
    @(negedge clk);
    chk("rst_gnt",     {28'b0, gnt},     32'd0);
    chk("rst_busy",    {31'b0, busy},    32'd0);
    chk("rst_count",   {28'b0, count},   32'd0);
    chk("rst_done",    {31'b0, done},    32'd0);
    chk("rst_aborted", {31'b0, aborted}, 32'd0);
    chk("rst_done_id", {30'b0, done_id}, 32'd0);
    rst = 1'b0;
    step();
    chk("idle_gnt", {28'b0, gnt}, 32'd0);

    // single requester, duration 3, held through regrant
    dur = {4'd0, 4'd0, 4'd0, 4'd3};
    req = 4'b0001;
    expect_end(1'b0, 2'd0, 4'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("single_gnt",   {28'b0, gnt},   32'd1);
      chk("single_busy",  {31'b0, busy},  32'd1);
      chk("single_count", {28'b0, count}, 32'(3 - k));
      step();
    end
    check_end("single_end");
    step();
    chk("regrant_gnt",   {28'b0, gnt},   32'd1);
    chk("regrant_count", {28'b0, count}, 32'd3);
    req = 4'b0000;
    expect_end(1'b1, 2'd0, 4'd3);
    step();
    check_end("regrant_abort");
    step();
    chk("idle_hold_gnt",   {28'b0, gnt},   32'd0);
    chk("idle_hold_busy",  {31'b0, busy},  32'd0);
    chk("idle_hold_count", {28'b0, count}, 32'd3);

    // zero duration on requester 2
    dur = '0;
    req = 4'b0100;
    expect_end(1'b0, 2'd2, 4'd0);
    step();
    chk("zero_gnt",   {28'b0, gnt},   32'h4);
    chk("zero_count", {28'b0, count}, 32'd0);
    step();
    check_end("zero_end");
    req = 4'b0000;
    step();
    chk("zero_after_gnt", {28'b0, gnt}, 32'd0);

    // abort in 3rd grant cycle, with non-winner and dur changes mid-slot
    dur = {4'd0, 4'd0, 4'd9, 4'd0};
    req = 4'b0010;
    step();
    chk("abort_c1_gnt",   {28'b0, gnt},   32'h2);
    chk("abort_c1_count", {28'b0, count}, 32'd9);
    step();
    chk("abort_c2_count", {28'b0, count}, 32'd8);
    req = 4'b0011;
    dur = '1;
    step();
    chk("abort_c3_gnt",   {28'b0, gnt},   32'h2);
    chk("abort_c3_count", {28'b0, count}, 32'd7);
    req = 4'b0000;
    expect_end(1'b1, 2'd1, 4'd7);
    step();
    check_end("abort_end");
    step();
    chk("abort_after_gnt", {28'b0, gnt}, 32'd0);

    // drop in the count==0 cycle: abort wins
    dur = {4'd1, 4'd0, 4'd0, 4'd0};
    req = 4'b1000;
    expect_end(1'b1, 2'd3, 4'd0);
    step();
    chk("coll_gnt",   {28'b0, gnt},   32'h8);
    chk("coll_count", {28'b0, count}, 32'd1);
    step();
    chk("coll_count0", {28'b0, count}, 32'd0);
    req = 4'b0000;
    step();
    check_end("coll_end");

    // reset mid-slot at count 5
    dur = {4'd0, 4'd0, 4'd0, 4'd8};
    req = 4'b0001;
    step();
    chk("mrst_count8", {28'b0, count}, 32'd8);
    step();
    step();
    step();
    chk("mrst_count5", {28'b0, count}, 32'd5);
    rst = 1'b1;
    #1;
    chk("mrst_gnt",     {28'b0, gnt},     32'd0);
    chk("mrst_busy",    {31'b0, busy},    32'd0);
    chk("mrst_count",   {28'b0, count},   32'd0);
    chk("mrst_done",    {31'b0, done},    32'd0);
    chk("mrst_aborted", {31'b0, aborted}, 32'd0);
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("mrst_after_done",    {31'b0, done},    32'd0);
    chk("mrst_after_aborted", {31'b0, aborted}, 32'd0);
    chk("mrst_after_gnt",     {28'b0, gnt},     32'd0);

    // contention, all requesters, duration 1
`ifdef TIMER_ARB_RR_EN
    ord = '{0, 1, 2, 3, 0};
`else
    ord = '{0, 0, 0};
`endif
    dur = {4'd1, 4'd1, 4'd1, 4'd1};
    req = 4'b1111;
    for (int s = 0; s < ord.size(); s++) begin
      expect_end(1'b0, 2'(ord[s]), 4'd0);
      step();
      chk("cont_gnt",   {28'b0, gnt},   32'd1 << ord[s]);
      chk("cont_count", {28'b0, count}, 32'd1);
      step();
      step();
      check_end("cont_end");
      if (s == ord.size() - 1) req = 4'b0000;
    end
    step();
    chk("cont_after_gnt", {28'b0, gnt}, 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
